fir_tap_sequencer: RTL and testbench
====================================

# fir_tap_sequencer

Serial controller for the 4-tap unsigned FIR datapath. It time-multiplexes a single multiply-accumulate across the taps instead of using four parallel multipliers. It also owns the 4-entry sample delay line and a runtime-writable coefficient bank. Samples enter and results leave through valid/ready handshakes, so the block sits between the sample source and any consumer that may stall.

## Interface
Parameters:
- DATA_W, default 8: sample and coefficient width.
- NTAPS, default 4: number of taps; fixed at 4 in this revision.
- ACC_W, default 2*DATA_W+2 (18): accumulator and result width. Sized so the sum cannot overflow.

Ports:
- clk, input, 1: sole clock. All state changes on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- x, input, DATA_W: input sample.
- x_valid, input, 1: x holds a sample.
- x_ready, output, 1: sequencer can accept a sample.
- y, output, ACC_W: filter result, registered.
- y_valid, output, 1: y holds an unconsumed result.
- y_ready, input, 1: consumer accepts y.
- cfg_we, input, 1: coefficient write strobe.
- cfg_addr, input, 2: coefficient index, 0..3.
- cfg_data, input, DATA_W: coefficient value.
- cfg_ready, output, 1: coefficient write will be taken this cycle.
- busy, output, 1: a sample is being processed (MAC or OUT).

## Operation
- The delay line d[0..3] holds the newest sample in d[0] and the oldest in d[3]. Coefficients c[0..3] reset to 1, 2, 3, 4.
- The result for each accepted sample is y = d0*c0 + d1*c1 + d2*c2 + d3*c3. The arithmetic is unsigned, products are DATA_W x DATA_W to 2*DATA_W, and the sum is taken at ACC_W with no truncation.
- The FSM has three states: IDLE, MAC and OUT.
  - IDLE: x_ready=1 and cfg_ready=1. When x_valid=1, the sample is accepted. The delay line shifts (d0<=x, d1<=d0, d2<=d1, d3<=d2), acc<=0, tap<=0, and the FSM goes to MAC.
  - MAC: x_ready=0 and cfg_ready=0. Each cycle, acc += d[tap]*c[tap] and tap increments. On the cycle with tap=3, y<=final sum and the FSM goes to OUT. The tap counter stops at 3 and does not wrap past it.
  - OUT: y_valid=1. When y_ready=1, the FSM goes to IDLE. While y_ready=0, y and y_valid hold steady.
- A coefficient write happens on cfg_we && cfg_ready and sets c[cfg_addr]<=cfg_data. Writes while not IDLE are dropped silently. The source must sample cfg_ready.
- If a sample is accepted and a coefficient is written in the same IDLE cycle, both take effect. The new coefficient is used for that sample's MAC pass.
- x_valid while not in IDLE is ignored. The sample is not consumed, and the source must hold it.
- busy=1 in MAC and OUT.

## Timing
- Reset (reset_n=0 at a clk edge) has these effects:
  - FSM goes to IDLE.
  - d[*]=0, acc=0, tap=0, y=0, y_valid=0.
  - c restored to 1, 2, 3, 4.
  - Registered outputs after reset: x_ready=1, cfg_ready=1, busy=0.
- Reset overrides every other input, including reset mid-MAC or mid-OUT. Any in-flight result is discarded and no y_valid pulse follows.
- Latency: the sample is accepted at edge k. The MAC edges are k+1..k+4, and y_valid is first high in the cycle after edge k+4.
- Throughput: at most one sample every 6 cycles (accept, 4 MAC, at least 1 OUT, back in IDLE). Each cycle of y_ready=0 in OUT adds one cycle.
- x_ready and cfg_ready are decoded from state only, with no combinational path from x_valid, y_ready or cfg_we.

## Structure
- Shared package fir_pkg holds:
  - DATA_W, NTAPS, ACC_W;
  - typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;
  - default-coefficient constant array FIR_COEFF_RST = {1, 2, 3, 4}.
- One sub-module, fir_coeff_bank, holds the 4 x DATA_W register file. It has a synchronous write, a combinational read by tap index, and resets to FIR_COEFF_RST.
- The FSM, delay line, tap counter and accumulator stay in the top.

## Test plan
- Impulse: default coefficients, samples 1, 0, 0, 0, 0 with y_ready=1 throughout. Required y sequence: 1, 2, 3, 4, 0. y_valid first high 5 cycles after the first accept.
- Full-scale step: five samples of 255. Required y sequence: 255, 765, 1530, 2550, 2550, with no overflow at ACC_W=18.
- Reprogram: in IDLE, write c = {10, 0, 0, 255}, then feed 1, 0, 0, 0. Required y sequence: 10, 0, 0, 255. A write attempted during MAC leaves c unchanged and cfg_ready reads 0.
- Simultaneous event: in the same IDLE cycle, a sample of 2 with c0 written to 7. Required y = 14, plus whatever older-tap contribution the delay line holds.
- Backpressure: hold y_ready=0 for 10 cycles in OUT. y and y_valid must stay stable and x_ready must stay 0. When y_ready rises, the FSM returns to IDLE in one cycle.
- Mid-operation reset: pull reset_n low for one cycle during the second MAC cycle. Afterwards y_valid=0, c={1, 2, 3, 4} and the delay line is zero, so the next sample of 5 gives y=5.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and reset coefficients for the FIR tap sequencer.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int NTAPS  = 4;
  localparam int ACC_W  = 2*DATA_W + 2;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  // Index 0 holds c0: c = {1, 2, 3, 4} for taps 0..3.
  localparam logic [NTAPS-1:0][DATA_W-1:0] FIR_COEFF_RST = {8'd4, 8'd3, 8'd2, 8'd1};

endpackage

// File: rtl/fir_coeff_bank.sv
// Runtime-writable coefficient register file: synchronous write, combinational read by tap.
module fir_coeff_bank #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int NTAPS  = fir_pkg::NTAPS,
  parameter int AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  import fir_pkg::*;

  logic [NTAPS-1:0][DATA_W-1:0] c_q;

  // Reset restores the default taps; otherwise one write per cycle when enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) c_q[i] <= DATA_W'(FIR_COEFF_RST[i]);
    end else if (we_i) begin
      c_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = c_q[raddr_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial 4-tap unsigned FIR: one MAC time-multiplexed across taps, valid/ready on both sides.
module fir_tap_sequencer #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int NTAPS  = fir_pkg::NTAPS,
  parameter int ACC_W  = 2*DATA_W + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] x,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [ACC_W-1:0]  y,
  output logic              y_valid,
  input  logic              y_ready,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              busy
);
  import fir_pkg::*;

  localparam int                TAP_W    = $clog2(NTAPS);
  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NTAPS-1);

  fir_state_t                   state_q;
  logic [NTAPS-1:0][DATA_W-1:0] d_q;
  logic [TAP_W-1:0]             tap_q;
  logic [ACC_W-1:0]             acc_q;
  logic [ACC_W-1:0]             acc_d;
  logic [ACC_W-1:0]             y_q;
  logic                         x_ready_q;
  logic                         cfg_ready_q;
  logic                         busy_q;
  logic                         y_valid_q;
  logic [DATA_W-1:0]            c_sel;
  logic [2*DATA_W-1:0]          prod;

  // Write is gated by the registered ready so a source that ignores cfg_ready
  // during MAC/OUT cannot disturb the pass in flight.
  fir_coeff_bank #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS),
    .AW     (TAP_W)
  ) u_coeff (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (cfg_we & cfg_ready_q),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (tap_q),
    .rdata_o (c_sel)
  );

  // Zero-extend both operands so the product is computed at full 2*DATA_W width.
  assign prod  = {{DATA_W{1'b0}}, d_q[tap_q]} * {{DATA_W{1'b0}}, c_sel};
  assign acc_d = acc_q + ACC_W'(prod);

  // Control FSM plus delay line, tap counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      x_ready_q   <= 1'b1;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_valid) begin
            d_q         <= {d_q[NTAPS-2:0], x};
            acc_q       <= '0;
            tap_q       <= '0;
            state_q     <= MAC;
            x_ready_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (tap_q == LAST_TAP) begin
            y_q       <= acc_d;
            y_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid_q   <= 1'b0;
            state_q     <= IDLE;
            x_ready_q   <= 1'b1;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          y_valid_q   <= 1'b0;
          x_ready_q   <= 1'b1;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign x_ready   = x_ready_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign y_valid   = y_valid_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: impulse, step, reprogram, simultaneous write, backpressure, mid-op reset.
module tb_fir_tap_sequencer;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  x        = '0;
  logic        x_valid  = 1'b0;
  logic        x_ready;
  logic [17:0] y;
  logic        y_valid;
  logic        y_ready  = 1'b1;
  logic        cfg_we   = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.DATA_W(8), .NTAPS(4), .ACC_W(18)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  // Entered at a negedge in IDLE with y_ready=1; returns at a negedge back in IDLE.
  task automatic run_sample(input logic [7:0] v, output logic [17:0] yo, output int lat);
    x = v; x_valid = 1'b1;
    @(posedge clk); #1 x_valid = 1'b0; cfg_we = 1'b0;
    lat = 0; yo = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (y_valid === 1'b1) begin lat = i; yo = y; break; end
    end
    if (lat == 0) $display("FAIL run_sample timeout: no y_valid within 20 cycles for x=%0d", v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = v;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_tests++; if (x_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_x_ready got=%b want=1", x_ready); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_tests++; if (y_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
    n_tests++; if (y !== 18'd0)        begin n_fail++; $display("FAIL reset_y got=%0d want=0", y); end
  endtask

  task automatic test_impulse();
    logic [7:0]  stim [5];
    logic [17:0] want [5];
    logic [17:0] got;
    int          lat;
    stim = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    want = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd0};
    for (int i = 0; i < 5; i++) begin
      run_sample(stim[i], got, lat);
      n_tests++; if (got !== want[i]) begin n_fail++; $display("FAIL impulse_y[%0d] got=%0d want=%0d", i, got, want[i]); end
      if (i == 0) begin
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL impulse_latency got=%0d want=5", lat); end
      end
    end
  endtask

  task automatic test_step();
    logic [17:0] want [5];
    logic [17:0] got;
    int          lat;
    want = '{18'd255, 18'd765, 18'd1530, 18'd2550, 18'd2550};
    for (int i = 0; i < 5; i++) begin
      run_sample(8'd255, got, lat);
      n_tests++; if (got !== want[i]) begin n_fail++; $display("FAIL step_y[%0d] got=%0d want=%0d", i, got, want[i]); end
    end
  endtask

  task automatic test_reprogram();
    logic [7:0]  stim [4];
    logic [17:0] want [4];
    logic [17:0] got;
    int          lat;
    bit          seen;
    // clear the 255s left in the delay line
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    cfg_write(2'd0, 8'd10);
    cfg_write(2'd1, 8'd0);
    cfg_write(2'd2, 8'd0);
    cfg_write(2'd3, 8'd255);
    stim = '{8'd1, 8'd0, 8'd0, 8'd0};
    want = '{18'd10, 18'd0, 18'd0, 18'd255};
    for (int i = 0; i < 4; i++) begin
      run_sample(stim[i], got, lat);
      n_tests++; if (got !== want[i]) begin n_fail++; $display("FAIL reprog_y[%0d] got=%0d want=%0d", i, got, want[i]); end
    end
    // attempt a write to c0 while the MAC pass for sample 0 is running
    x = 8'd0; x_valid = 1'b1;
    @(posedge clk); #1 x_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mac_cfg_ready got=%b want=0", cfg_ready); end
    n_tests++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL mac_busy got=%b want=1", busy); end
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd99;
    @(negedge clk);
    cfg_we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (y_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!seen || y !== 18'd0) begin n_fail++; $display("FAIL mac_write_y seen=%b got=%0d want=0", seen, y); end
    @(posedge clk); @(negedge clk);
    run_sample(8'd1, got, lat);
    n_tests++; if (got !== 18'd10) begin n_fail++; $display("FAIL mac_write_dropped got=%0d want=10", got); end
  endtask

  task automatic test_simultaneous();
    logic [17:0] got;
    int          lat;
    // d={1,0,0,0} and c={10,0,0,255}: new c0=7 with x=2 gives 2*7 + 1*0 = 14
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd7;
    run_sample(8'd2, got, lat);
    n_tests++; if (got !== 18'd14) begin n_fail++; $display("FAIL simul_y got=%0d want=14", got); end
  endtask

  task automatic test_backpressure();
    bit seen;
    bit stable;
    // d becomes {3,2,1,0}, c={7,0,0,255}: 3*7 = 21
    y_ready = 1'b0;
    x = 8'd3; x_valid = 1'b1;
    @(posedge clk); #1 x_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (y_valid === 1'b1) begin seen = 1'b1; break; end
    end
    n_tests++; if (!seen || y !== 18'd21) begin n_fail++; $display("FAIL bp_y seen=%b got=%0d want=21", seen, y); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      if (y !== 18'd21 || y_valid !== 1'b1 || x_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL bp_hold got y=%0d y_valid=%b x_ready=%b want 21/1/0", y, y_valid, x_ready); end
    y_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (x_ready !== 1'b1 || y_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got x_ready=%b y_valid=%b busy=%b want 1/0/0", x_ready, y_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] got;
    int          lat;
    bit          pulse;
    x = 8'd9; x_valid = 1'b1;
    @(posedge clk); #1 x_valid = 1'b0;
    @(negedge clk);              // first MAC cycle
    @(negedge clk);              // second MAC cycle
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      if (y_valid !== 1'b0) pulse = 1'b1;
    end
    n_tests++; if (pulse) begin n_fail++; $display("FAIL midrst_no_pulse got y_valid=1 want=0"); end
    n_tests++; if (x_ready !== 1'b1 || busy !== 1'b0 || y !== 18'd0) begin
      n_fail++; $display("FAIL midrst_state got x_ready=%b busy=%b y=%0d want 1/0/0", x_ready, busy, y);
    end
    run_sample(8'd5, got, lat);
    n_tests++; if (got !== 18'd5) begin n_fail++; $display("FAIL midrst_next_y got=%0d want=5", got); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_reprogram();
    test_simultaneous();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
